// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared FSM encoding and width defaults for the counter sequencer
package counter_seq_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int PRE_W_DEF = 26;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// tick_gen: prescaler that emits one tick every prescale+1 qualified cycles
module tick_gen
   import counter_seq_pkg::*;
#(
   parameter int PRE_W = PRE_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   input  logic             zero,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);
   logic [PRE_W-1:0] pre_cnt;
   assign tick = advance && (pre_cnt == prescale);
   // phase counter: restart on zero, hold unless advancing, reset on each tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pre_cnt <= '0;
      else if (zero) pre_cnt <= '0;
      else if (advance) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
   end
endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: run/pause/done FSM owning the display count register
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int PRE_W = PRE_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             auto_reload,
   input  logic [PRE_W-1:0] prescale,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
   output logic             tick,
   output logic             wrap,
   output logic [1:0]       state
);
   state_t cur, nxt;
   logic [WIDTH-1:0] count_nxt;
   logic wrap_nxt, start_cmd, advance, zero;
   // start only counts when no higher-priority command is present
   assign start_cmd = start && !clear && !stop;
   assign advance = (cur == RUN) && !clear && !stop;
   assign zero = clear || (start_cmd && (cur == IDLE || cur == DONE));
   assign running = (cur == RUN);
   assign done = (cur == DONE);
   assign state = cur;
   tick_gen #(.PRE_W(PRE_W)) u_tick (
      .clk(clk),
      .reset(reset),
      .advance(advance),
      .zero(zero),
      .prescale(prescale),
      .tick(tick)
   );
   // state, count and wrap pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur <= IDLE;
         count <= '0;
         wrap <= 1'b0;
      end else begin
         cur <= nxt;
         count <= count_nxt;
         wrap <= wrap_nxt;
      end
   end
   // command decode (clear > stop > start) then terminal handling on tick
   always_comb begin
      nxt = cur;
      count_nxt = count;
      wrap_nxt = 1'b0;
      if (clear) begin
         nxt = IDLE;
         count_nxt = '0;
      end else if (stop) begin
         nxt = (cur == RUN) ? PAUSE : cur;
      end else if (start && cur != RUN) begin
         nxt = RUN;
         count_nxt = (cur == DONE) ? '0 : count;
      end else if (tick) begin
         if (count >= limit) begin
            nxt = auto_reload ? RUN : DONE;
            count_nxt = auto_reload ? '0 : count;
            wrap_nxt = auto_reload;
         end else begin
            count_nxt = count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed stimulus with a tick-driven scoreboard monitor
module tb_counter_sequencer;
   typedef struct {
      int         cyc;
      logic [15:0] cnt;
      logic       wr;
   } exp_t;

   logic clk, reset, start, stop, clear, auto_reload;
   logic [25:0] prescale;
   logic [15:0] limit, count;
   logic running, done, tick, wrap;
   logic [1:0] state;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic exp_wrap = 1'b0;
   exp_t q[$];

   counter_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .auto_reload(auto_reload), .prescale(prescale), .limit(limit),
      .count(count), .running(running), .done(done), .tick(tick),
      .wrap(wrap), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every tick must match the next queued expectation; wrap follows a tick by one cycle
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         exp_wrap = 1'b0;
      end else begin
         checks++;
         if (wrap !== exp_wrap) begin
            errors++;
            $display("FAIL wrap cyc=%0d got=%b want=%b", cyc, wrap, exp_wrap);
         end
         exp_wrap = 1'b0;
         if (tick) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_tick cyc=%0d count=%0d", cyc, count);
            end else begin
               e = q.pop_front();
               if (cyc !== e.cyc || count !== e.cnt) begin
                  errors++;
                  $display("FAIL tick cyc=%0d count=%0d want cyc=%0d count=%0d", cyc, count, e.cyc, e.cnt);
               end
               exp_wrap = e.wr;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input logic [15:0] v, input logic w);
      exp_t e;
      e.cyc = c;
      e.cnt = v;
      e.wr = w;
      q.push_back(e);
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(output int n);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = cyc;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int n, r;
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      clear = 1'b0;
      auto_reload = 1'b0;
      prescale = 26'd0;
      limit = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      // one-shot to limit 5 at full rate
      prescale = 26'd0;
      limit = 16'd5;
      pulse_start(n);
      chk("t1_state_run", 32'(state), 32'd1);
      chk("t1_running", 32'(running), 32'd1);
      chk("t1_count0", 32'(count), 32'd0);
      for (int i = 0; i < 6; i++) push(n + i, 16'(i), 1'b0);
      goto_cyc(n + 6);
      chk("t1_state_done", 32'(state), 32'd3);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_running_off", 32'(running), 32'd0);
      chk("t1_count5", 32'(count), 32'd5);
      goto_cyc(n + 8);
      chk("t1_count_hold", 32'(count), 32'd5);
      // restart from DONE
      pulse_start(n);
      chk("t5_state", 32'(state), 32'd1);
      chk("t5_count0", 32'(count), 32'd0);
      for (int i = 0; i < 6; i++) push(n + i, 16'(i), 1'b0);
      goto_cyc(n + 6);
      chk("t5_done_again", 32'(state), 32'd3);
      chk("t5_count5", 32'(count), 32'd5);
      // simultaneous clear+stop+start while running at count 7
      pulse_clear();
      chk("t4_idle", 32'(state), 32'd0);
      chk("t4_cleared", 32'(count), 32'd0);
      limit = 16'd100;
      pulse_start(n);
      for (int i = 0; i < 7; i++) push(n + i, 16'(i), 1'b0);
      goto_cyc(n + 7);
      chk("t4_count7", 32'(count), 32'd7);
      clear = 1'b1;
      stop = 1'b1;
      start = 1'b1;
      goto_cyc(n + 8);
      clear = 1'b0;
      stop = 1'b0;
      start = 1'b0;
      chk("t4_state_idle", 32'(state), 32'd0);
      chk("t4_count_zero", 32'(count), 32'd0);
      chk("t4_not_running", 32'(running), 32'd0);
      // prescale 3 with pause/resume preserving phase
      prescale = 26'd3;
      limit = 16'hFFFF;
      pulse_start(n);
      push(n + 3, 16'd0, 1'b0);
      push(n + 7, 16'd1, 1'b0);
      goto_cyc(n + 9);
      chk("t2_count2", 32'(count), 32'd2);
      stop = 1'b1;
      goto_cyc(n + 10);
      stop = 1'b0;
      chk("t2_paused", 32'(state), 32'd2);
      chk("t2_pause_count", 32'(count), 32'd2);
      goto_cyc(n + 13);
      chk("t2_pause_hold", 32'(count), 32'd2);
      pulse_start(r);
      chk("t2_resumed", 32'(state), 32'd1);
      push(r + 2, 16'd2, 1'b0);
      push(r + 6, 16'd3, 1'b0);
      goto_cyc(r + 3);
      chk("t2_count3", 32'(count), 32'd3);
      goto_cyc(r + 7);
      chk("t2_count4", 32'(count), 32'd4);
      pulse_clear();
      // auto-reload wrap at limit 3
      prescale = 26'd0;
      limit = 16'd3;
      auto_reload = 1'b1;
      pulse_start(n);
      for (int i = 0; i < 9; i++) push(n + i, 16'(i % 4), (i % 4) == 3);
      goto_cyc(n + 4);
      chk("t3_wrapped_count", 32'(count), 32'd0);
      chk("t3_state_run", 32'(state), 32'd1);
      chk("t3_no_done", 32'(done), 32'd0);
      goto_cyc(n + 9);
      chk("t3_no_done_end", 32'(done), 32'd0);
      clear = 1'b1;
      goto_cyc(n + 10);
      clear = 1'b0;
      auto_reload = 1'b0;
      chk("t3_cleared", 32'(state), 32'd0);
      // asynchronous reset mid-run
      limit = 16'd100;
      pulse_start(n);
      for (int i = 0; i < 3; i++) push(n + i, 16'(i), 1'b0);
      goto_cyc(n + 3);
      reset = 1'b1;
      #2;
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_state", 32'(state), 32'd0);
      chk("t6_running", 32'(running), 32'd0);
      chk("t6_tick", 32'(tick), 32'd0);
      chk("t6_wrap", 32'(wrap), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      pulse_start(n);
      chk("t6_restart_count", 32'(count), 32'd0);
      for (int i = 0; i < 3; i++) push(n + i, 16'(i), 1'b0);
      goto_cyc(n + 3);
      chk("t6_restart_count3", 32'(count), 32'd3);
      clear = 1'b1;
      goto_cyc(n + 4);
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control block for the 16-bit up-counter datapath whose nibbles feed the four hex_display decoders. It owns the count register and sequences it with a run/pause/done FSM, a programmable prescaler and a programmable terminal value. It supports one-shot or auto-reload modes. Board-level glue maps push-buttons and switches onto its command inputs and routes count[15:0] to HEX3..HEX0.

Parameters:
WIDTH, 16, count register width.
PRE_W, 26, prescaler counter width (26 bits covers a 1 s tick at 50 MHz).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  start/resume command, sampled each cycle (level; one cycle = one command).
stop  input  1  pause command.
clear  input  1  clear command.
auto_reload  input  1  1 = wrap to 0 at terminal; 0 = stop in DONE.
prescale  input  PRE_W  tick period minus 1, in clk cycles.
limit  input  WIDTH  terminal count value.
count  output  WIDTH  current count, to the hex decoders.
running  output  1  high while the FSM is in RUN.
done  output  1  high while the FSM is in DONE.
tick  output  1  one-cycle pulse on each count step (combinational from registers).
wrap  output  1  registered one-cycle pulse when an auto-reload wrap occurs.
state  output  2  FSM state, for debug LEDs.

Behaviour:
- reset asserted (async): state=IDLE, count=0, pre_cnt=0, wrap=0, running=0, done=0, tick=0. Reset mid-run discards everything with no residual tick.
- States and encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3. running=(state==RUN); done=(state==DONE).
- Command priority per cycle: clear > stop > start. Only the highest-priority active command takes effect.
- clear (any state): count=0, pre_cnt=0, state=IDLE. Tick is suppressed that cycle.
- stop: RUN→PAUSE. count and pre_cnt are held, so the prescaler phase is preserved. Ignored in IDLE, PAUSE and DONE.
- start:
  - IDLE→RUN with pre_cnt=0.
  - PAUSE→RUN, resuming pre_cnt.
  - DONE→RUN with count=0 and pre_cnt=0.
  - Ignored in RUN.
- Prescaler: only advances in RUN with no command active.
  - tick = (state==RUN) && (pre_cnt==prescale) && !clear && !stop.
  - On tick, pre_cnt←0; otherwise pre_cnt←pre_cnt+1.
  - prescale=0 gives a tick every cycle.
- Latency: start sampled at edge N gives running=1 after edge N. The first tick is high in cycle N+prescale+1, and count updates at the following edge.
- Count step on tick:
  - If count >= limit (unsigned): with auto_reload=1, count←0 and wrap←1 for one cycle. With auto_reload=0, count holds and state←DONE.
  - Otherwise count←count+1.
- Terminal uses >=, so lowering limit below count mid-run terminates on the next tick. limit=0 terminates on the first tick, and count stays 0. limit=0xFFFF never overflows the width.
- prescale and limit may change at any time and take effect from the next cycle. If prescale is lowered below pre_cnt, pre_cnt keeps counting and wraps naturally at 2^PRE_W before matching. This is acceptable and documented behaviour.
- wrap is 0 in every cycle without a reload, and never high together with a DONE transition.

Decomposition:
- Package counter_seq_pkg: state localparams IDLE/RUN/PAUSE/DONE, WIDTH and PRE_W defaults.
- Sub-module tick_gen: owns pre_cnt and produces tick from prescale and the run/hold/clear qualifiers.
- The FSM and count register stay in counter_sequencer. hex_display is instantiated at board level, not here.

Test Plan:
1. Reset, then prescale=0, limit=5, auto_reload=0, pulse start → count steps 0..5 on consecutive cycles. done=1 and state=3 one edge after count reaches 5 with tick high; count holds at 5.
2. prescale=3, limit=0xFFFF, start → tick exactly every 4th cycle. stop after count=2 → count holds at 2 and pre_cnt holds its phase. start → next tick arrives after the remaining phase cycles, count=3.
3. prescale=0, limit=3, auto_reload=1 → count sequence 0,1,2,3,0,1…. wrap pulses for one cycle coinciding with each 3→0 transition; done never asserts.
4. Simultaneous clear+stop+start while in RUN at count=7 → next state IDLE, count=0, no tick that cycle.
5. In DONE at count=5, pulse start → count=0, state RUN; the count restarts normally.
6. Assert reset asynchronously mid-RUN between clock edges → all outputs go to reset values immediately, before the next clk edge. Deassert, pulse start → run restarts from 0.
